// File: rtl/bin7seg_pkg.sv
// Shared types and constants for the sequential binary-to-seven-segment converter.
package bin7seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    // Decimal digits needed for a WIDTH-bit value: ceil(width * log10(2)).
    function automatic int min_digits(input int width);
        longint scaled;
        scaled = longint'(width) * 64'sd30103;
        return int'((scaled + 64'sd99999) / 64'sd100000);
    endfunction

endpackage

// File: rtl/bin_to_7seg_seq_decode.sv
// One BCD digit to seven segments, with blanking applied before polarity.
module seg7_decode
    import bin7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg_hi = SEG_0;
                4'd1:    seg_hi = SEG_1;
                4'd2:    seg_hi = SEG_2;
                4'd3:    seg_hi = SEG_3;
                4'd4:    seg_hi = SEG_4;
                4'd5:    seg_hi = SEG_5;
                4'd6:    seg_hi = SEG_6;
                4'd7:    seg_hi = SEG_7;
                4'd8:    seg_hi = SEG_8;
                4'd9:    seg_hi = SEG_9;
                default: seg_hi = SEG_BLANK;
            endcase
        end
    end

    assign seg = ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/bin_to_7seg_seq.sv
// Iterative (double dabble, one bit per clock) binary to BCD and seven-segment converter
// with a start/busy/done handshake and registered display outputs.
module bin_to_7seg_seq
    import bin7seg_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter bit BLANK_LZ   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [6:0] SEG_RST = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    generate
        if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_params
            $error("bin_to_7seg_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t                  state;
    logic [WIDTH-1:0]        bin_sh;
    logic [DIGITS-1:0][3:0]  bcd_sh;
    logic [DIGITS-1:0][3:0]  bcd_adj;
    logic [CNT_W-1:0]        cnt;
    logic [DIGITS-1:0]       lz;
    logic [DIGITS-1:0]       blank;
    logic [DIGITS-1:0][6:0]  seg_nxt;

    always_comb begin
        bcd_adj = bcd_sh;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sh[k] >= 4'd5) bcd_adj[k] = bcd_sh[k] + 4'd3;
        end
    end

    // lz[k]: digits k..DIGITS-1 are all zero; the ones digit is never blanked.
    always_comb begin
        lz    = '0;
        blank = '0;
        lz[DIGITS-1] = (bcd_sh[DIGITS-1] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lz[k] = lz[k+1] && (bcd_sh[k] == 4'd0);
        end
        for (int k = 1; k < DIGITS; k++) begin
            blank[k] = BLANK_LZ && lz[k];
        end
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_dec
            seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
                .bcd   (bcd_sh[k]),
                .blank (blank[k]),
                .seg   (seg_nxt[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_sh  <= '0;
            bcd_sh  <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            seg_out <= {DIGITS{SEG_RST}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sh <= bin_in;
                        bcd_sh <= '0;
                        cnt    <= CNT_W'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
                    if (cnt == '0) state <= LOAD;
                    else           cnt   <= cnt - 1'b1;
                end
                LOAD: begin
                    bcd_out <= bcd_sh;
                    seg_out <= seg_nxt;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_7seg_seq.sv
// Directed checks of the sequential converter in three parameterisations.
module tb_bin_to_7seg_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // DUT A: WIDTH=8, DIGITS=3, BLANK_LZ=1, ACTIVE_LOW=0
    logic        start_a = 1'b0;
    logic [7:0]  bin_a = '0;
    logic        busy_a, done_a;
    logic [11:0] bcd_a;
    logic [20:0] seg_a;

    // DUT B: WIDTH=8, DIGITS=3, BLANK_LZ=0, ACTIVE_LOW=1
    logic        start_b = 1'b0;
    logic [7:0]  bin_b = '0;
    logic        busy_b, done_b;
    logic [11:0] bcd_b;
    logic [20:0] seg_b;

    // DUT C: WIDTH=16, DIGITS=5, BLANK_LZ=1, ACTIVE_LOW=0
    logic        start_c = 1'b0;
    logic [15:0] bin_c = '0;
    logic        busy_c, done_c;
    logic [19:0] bcd_c;
    logic [34:0] seg_c;

    bin_to_7seg_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .seg_out(seg_a));

    bin_to_7seg_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .seg_out(seg_b));

    bin_to_7seg_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .bin_in(bin_c),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .seg_out(seg_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each run task returns the number of edges from the accepting edge to the done edge.
    task automatic run_a(input logic [7:0] v, output int lat);
        @(negedge clk); start_a = 1'b1; bin_a = v;
        @(negedge clk); start_a = 1'b0; lat = 0;
        while (!done_a && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic run_b(input logic [7:0] v, output int lat);
        @(negedge clk); start_b = 1'b1; bin_b = v;
        @(negedge clk); start_b = 1'b0; lat = 0;
        while (!done_b && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic wait_c(output int lat);
        lat = 0;
        while (!done_c && lat < 60) begin @(negedge clk); lat++; end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_bcd_a",  bcd_a,  12'h000);
        chk("rst_seg_a",  seg_a,  21'h0);
        chk("rst_seg_b",  seg_b,  {7'h7F, 7'h7F, 7'h7F});
        chk("rst_seg_c",  seg_c,  35'h0);
        rst_n = 1'b1;

        // Zero: ones digit shown, upper digits blanked
        run_a(8'd0, lat);
        chk("zero_lat", lat, 9);
        chk("zero_bcd", bcd_a, 12'h000);
        chk("zero_seg", seg_a, {7'h00, 7'h00, 7'h3F});
        @(negedge clk);
        chk("zero_done_1cyc", done_a, 1'b0);

        run_a(8'd255, lat);
        chk("max_lat", lat, 9);
        chk("max_bcd", bcd_a, 12'h255);
        chk("max_seg", seg_a, {7'h5B, 7'h6D, 7'h6D});
        chk("max_busy_done", busy_a, 1'b0);

        run_a(8'd105, lat);
        chk("interior_bcd", bcd_a, 12'h105);
        chk("interior_seg", seg_a, {7'h06, 7'h3F, 7'h6D});

        // Start while busy is ignored
        @(negedge clk); start_a = 1'b1; bin_a = 8'd12;
        @(negedge clk); start_a = 1'b0;
        busy_cnt = 0; done_cnt = 0; lat = -1;
        for (int i = 0; i < 22; i++) begin
            if (busy_a) busy_cnt++;
            if (done_a) begin done_cnt++; lat = i; end
            if (i == 2) begin start_a = 1'b1; bin_a = 8'd200; end
            if (i == 3) start_a = 1'b0;
            @(negedge clk);
        end
        chk("ign_busy_cycles", busy_cnt, 9);
        chk("ign_done_count", done_cnt, 1);
        chk("ign_done_lat", lat, 9);
        chk("ign_bcd", bcd_a, 12'h012);
        chk("ign_seg", seg_a, {7'h00, 7'h06, 7'h5B});

        // Reset mid-conversion discards the partial result
        @(negedge clk); start_a = 1'b1; bin_a = 8'd77;
        @(negedge clk); start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_done", done_a, 1'b0);
        chk("mid_rst_bcd",  bcd_a,  12'h000);
        chk("mid_rst_seg",  seg_a,  21'h0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        chk("mid_rst_no_done", done_cnt, 0);
        run_a(8'd42, lat);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_bcd", bcd_a, 12'h042);
        chk("post_rst_seg", seg_a, {7'h00, 7'h66, 7'h5B});

        // Active-low, no blanking
        run_b(8'd7, lat);
        chk("al_lat", lat, 9);
        chk("al_bcd", bcd_b, 12'h007);
        chk("al_seg", seg_b, {7'h40, 7'h40, 7'h78});

        // Wide variant with back-to-back start in the done cycle
        @(negedge clk); start_c = 1'b1; bin_c = 16'd65535;
        @(negedge clk); start_c = 1'b0;
        wait_c(lat);
        chk("w16_lat", lat, 17);
        chk("w16_bcd", bcd_c, 20'h65535);
        chk("w16_seg", seg_c, {7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h6D});
        start_c = 1'b1; bin_c = 16'd1;
        @(negedge clk); start_c = 1'b0;
        chk("b2b_busy", busy_c, 1'b1);
        wait_c(lat);
        chk("b2b_lat", lat, 17);
        chk("b2b_bcd", bcd_c, 20'h00001);
        chk("b2b_seg", seg_c, {7'h00, 7'h00, 7'h00, 7'h00, 7'h06});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_7seg_seq.md
# bin_to_7seg_seq

Sequential, parametrised binary-to-seven-segment converter: successor to the combinational 8-bit/3-digit converter, generalised to any input width and digit count. It captures a binary word on a start/busy/done handshake and converts it iteratively with shift-add-3 (double dabble), one bit per clock. It then drives registered, optionally leading-zero-blanked, optionally active-low segment patterns for all digits. It sits between datapath result registers and the board display pins.

## Interface
- WIDTH, 8: binary input width; ≥ 1.
- DIGITS, 3: number of decimal digits.
  - Must be ≥ ceil(WIDTH·log10 2); elaboration error otherwise.
- BLANK_LZ, 1: 1 blanks leading-zero digits; the ones digit is always shown.
- ACTIVE_LOW, 0: 1 inverts every segment bit (common-anode boards).
- clk  in  1  rising-edge clock; the single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  conversion request; sampled only when busy = 0.
- bin_in  in  WIDTH  unsigned value; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when seg_out/bcd_out update.
- bcd_out  out  4·DIGITS  registered BCD result; digit 0 (ones) at [3:0].
- seg_out  out  7·DIGITS  registered segments; digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE, CONV, LOAD.
  - IDLE: start=1 → capture bin_in into the shift register, clear the BCD scratch, iteration counter = WIDTH−1, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. Counter = 0 → go to LOAD; otherwise decrement.
  - LOAD: register bcd_out and seg_out, pulse done, return to IDLE.
- busy = (state ≠ IDLE).
- start while busy is ignored: no queueing, bin_in not re-sampled.
- Decode digits 0–9 (active-high, gfedcba):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - BCD values 10–15 cannot occur; decode them as blank.
- Blank pattern = 00 before polarity. ACTIVE_LOW inverts after blanking, so blank = 7F.
- Leading-zero blanking (BLANK_LZ=1): digit k>0 is blanked iff digits k..DIGITS−1 are all zero. Interior zeros (e.g. 105) are displayed.
- Reset (rst_n=0 at an edge) from any state, including mid-CONV:
  - state → IDLE; busy = 0, done = 0, bcd_out = 0.
  - seg_out = blank pattern on every digit, including ones.
  - A partial conversion is discarded.

## Timing
- Accepted start at edge T → busy = 1 after T.
- WIDTH CONV edges: T+1 … T+WIDTH.
- LOAD edge T+WIDTH+1: outputs update, done = 1 and busy = 0 for the following cycle.
- Latency start → done = WIDTH+1 cycles; throughput one conversion per WIDTH+1 cycles.
  - A start held high through the done cycle is accepted in that cycle (back-to-back).
- seg_out/bcd_out hold their last value between conversions; they change only on the LOAD edge or reset.
- WIDTH = 1: a single CONV cycle; latency 2.

## Structure
- Package bin7seg_pkg holds:
  - the state enum;
  - SEG_BLANK and the 0–9 segment constants;
  - a constant function min_digits(width) used for the DIGITS legality check.
- Sub-module seg7_decode: combinational 4-bit BCD + blank + ACTIVE_LOW → 7 bits. Instantiated DIGITS times via generate.

## Test plan
- WIDTH=8, DIGITS=3, BLANK_LZ=1: start with 0 → done after 9 cycles; seg_out = {00, 00, 3F}; bcd_out = 000.
- 255 → bcd_out = 255; seg_out = {5B, 6D, 6D}. Then 105 → {06, 3F, 6D}: interior zero shown.
- Start at T, pulse start again at T+3 with a different bin_in:
  - second request ignored;
  - single done at T+9;
  - busy high T+1…T+9.
- Assert rst_n=0 mid-CONV at T+4 → next cycle busy = 0, done never pulses, seg_out all 00. A fresh start converts correctly.
- ACTIVE_LOW=1, BLANK_LZ=0, input 7 → seg_out = {40, 40, 78}: inverted 3F, 3F, 07.
- WIDTH=16, DIGITS=5: 65535 → bcd_out = 65535, done latency 17; back-to-back start in the done cycle with 1 → done again 17 cycles later, seg_out = {00, 00, 00, 00, 06}.
